// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file and its clear sequencer.
// Holds the clear-FSM state encoding, the default geometry and the byte-lane helper.
package regfile_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_DEPTH  = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DONE
  } clr_state_t;

  function automatic int byte_lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Bulk-clear sequencer: walks every entry once, one per cycle, then a single done cycle.
// Latency: DEPTH sweep cycles + 1 done cycle; clr_req is ignored while busy (SWEEP and DONE).
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    busy      = 1'b0;
    clr_done  = 1'b0;
    clr_we    = 1'b0;
    clr_addr  = ptr;
    case (state)
      ST_IDLE: begin
        ptr_nxt = '0;
        if (clr_req) state_nxt = ST_SWEEP;
      end
      ST_SWEEP: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        // Pointer never wraps: the last entry hands over to DONE instead.
        if (ptr == LAST_ADDR) begin
          state_nxt = ST_DONE;
          ptr_nxt   = '0;
        end else begin
          ptr_nxt = ptr + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        clr_done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/regfile_param.sv
// NRD-read / 1-write register file with byte enables, optional zero register and bulk clear.
// Reads are combinational; writes land on the edge and are dropped while BUSY. REGFILE_BYPASS_EN adds same-cycle forwarding.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  WR_EN,
  input  logic [ADDR_W-1:0]     WR_ADDR,
  input  logic [DATA_W/8-1:0]   WR_BE,
  input  logic [DATA_W-1:0]     WR_DATA,
  output logic                  WR_ACCEPT,
  input  logic [NRD*ADDR_W-1:0] RD_ADDR,
  output logic [NRD*DATA_W-1:0] RD_DATA,
  input  logic                  CLR_REQ,
  output logic                  BUSY,
  output logic                  CLR_DONE
);

  localparam int NBE = byte_lanes(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_req;
  logic              wr_is_zero;
  logic              wr_commit;
  logic [DATA_W-1:0] wr_merged;

  regfile_clr_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .clr_req  (CLR_REQ),
    .busy     (BUSY),
    .clr_done (CLR_DONE),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Writes to the zero register are acknowledged but never reach storage.
  assign wr_req     = WR_EN & ~BUSY;
  assign WR_ACCEPT  = wr_req & RESET_N;
  assign wr_is_zero = (ZERO_R0 != 0) && (WR_ADDR == '0);
  assign wr_commit  = wr_req & ~wr_is_zero;

  always_comb begin
    wr_merged = mem[WR_ADDR];
    for (int b = 0; b < NBE; b++) begin
      if (WR_BE[b]) wr_merged[8*b +: 8] = WR_DATA[8*b +: 8];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_commit) begin
      mem[WR_ADDR] <= wr_merged;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = RD_ADDR[p*ADDR_W +: ADDR_W];

    always_comb begin
      rd = mem[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr_commit && (WR_ADDR == ra)) rd = wr_merged;
`endif
      if ((ZERO_R0 != 0) && (ra == '0)) rd = '0;
    end

    assign RD_DATA[p*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param (64b x 32, 2 read ports, zero register).
// Stimulus pushes expected outputs per cycle; a negedge monitor pops and compares them.
module tb_regfile_param;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic         WR_EN;
  logic [4:0]   WR_ADDR;
  logic [7:0]   WR_BE;
  logic [63:0]  WR_DATA;
  logic         WR_ACCEPT;
  logic [9:0]   RD_ADDR;
  logic [127:0] RD_DATA;
  logic         CLR_REQ;
  logic         BUSY;
  logic         CLR_DONE;

  always #5 CLK = ~CLK;

  regfile_param #(
    .DATA_W  (64),
    .DEPTH   (32),
    .NRD     (2),
    .ZERO_R0 (1)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .WR_EN     (WR_EN),
    .WR_ADDR   (WR_ADDR),
    .WR_BE     (WR_BE),
    .WR_DATA   (WR_DATA),
    .WR_ACCEPT (WR_ACCEPT),
    .RD_ADDR   (RD_ADDR),
    .RD_DATA   (RD_DATA),
    .CLR_REQ   (CLR_REQ),
    .BUSY      (BUSY),
    .CLR_DONE  (CLR_DONE)
  );

  // kind: 0 = read port 0, 1 = read port 1, 2 = WR_ACCEPT, 3 = BUSY, 4 = CLR_DONE
  typedef struct {
    string       name;
    int          kind;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: plain array of entries plus "cycles since the clear request"
  // (0 = idle, 1..32 = entry n-1 is wiped on the coming edge, 33 = done cycle).
  logic [63:0] ref_mem [32];
  int          sw_n = 0;

  function automatic bit busy_m();
    return (sw_n >= 1) && (sw_n <= 33);
  endfunction

  function automatic bit done_m();
    return sw_n == 33;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                         input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] exp_rd(input int a);
    logic [63:0] v;
    v = (a == 0) ? 64'd0 : ref_mem[a];
`ifdef REGFILE_BYPASS_EN
    if (WR_EN && !busy_m() && RESET_N && (a == int'(WR_ADDR)) && (a != 0))
      v = merge(v, WR_DATA, WR_BE);
`endif
    return v;
  endfunction

  task automatic push(input string n, input int k, input logic [63:0] v);
    exp_t e;
    e.name = n;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic reset_model();
    for (int i = 0; i < 32; i++) ref_mem[i] = 64'd0;
    sw_n = 0;
  endtask

  // Called at posedge+1: drive one cycle of inputs and queue the model's view of every output.
  task automatic drive(input bit we, input int wa, input logic [7:0] be, input logic [63:0] wd,
                       input int a0, input int a1, input bit clr);
    WR_EN   = we;
    WR_ADDR = wa[4:0];
    WR_BE   = be;
    WR_DATA = wd;
    RD_ADDR = {a1[4:0], a0[4:0]};
    CLR_REQ = clr;
    push("rd_port0", 0, exp_rd(a0));
    push("rd_port1", 1, exp_rd(a1));
    push("wr_accept", 2, 64'(we && !busy_m() && RESET_N));
    push("busy", 3, 64'(busy_m()));
    push("clr_done", 4, 64'(done_m()));
  endtask

  // Advance one edge and apply its effect to the model.
  task automatic tick();
    bit acc;
    bit clr;
    int wa;
    acc = WR_EN && !busy_m() && RESET_N;
    clr = CLR_REQ;
    wa  = int'(WR_ADDR);
    @(posedge CLK);
    #1;
    if (!RESET_N) begin
      reset_model();
    end else begin
      if (acc && wa != 0) ref_mem[wa] = merge(ref_mem[wa], WR_DATA, WR_BE);
      if (sw_n == 0) begin
        if (clr) sw_n = 1;
      end else if (sw_n <= 32) begin
        ref_mem[sw_n-1] = 64'd0;
        sw_n++;
      end else begin
        sw_n = 0;
      end
    end
  endtask

  always @(negedge CLK) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [63:0] act;
      e = sb.pop_front();
      case (e.kind)
        0:       act = RD_DATA[63:0];
        1:       act = RD_DATA[127:64];
        2:       act = {63'd0, WR_ACCEPT};
        3:       act = {63'd0, BUSY};
        default: act = {63'd0, CLR_DONE};
      endcase
      checks++;
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s actual=%h expected=%h t=%0t", e.name, act, e.val, $time);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET_N = 1'b0;
    WR_EN   = 1'b0;
    WR_ADDR = '0;
    WR_BE   = '0;
    WR_DATA = '0;
    RD_ADDR = '0;
    CLR_REQ = 1'b0;
    reset_model();

    // Reset: outputs quiet even with a write request pending.
    @(posedge CLK);
    #1;
    drive(1, 0, 8'hFF, 64'hFFFF, 0, 5, 0);
    push("reset_wr_accept", 2, 64'd0);
    push("reset_busy", 3, 64'd0);
    push("reset_clr_done", 4, 64'd0);
    tick();
    RESET_N = 1'b1;

    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 8'h00, 64'd0, i, 31 - i, 0);
      push("reset_rd0_zero", 0, 64'd0);
      push("reset_rd1_zero", 1, 64'd0);
      tick();
    end

    // Byte-enable merge.
    drive(1, 5, 8'hFF, 64'h1122334455667788, 5, 6, 0);
    tick();
    drive(1, 5, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 6, 7, 0);
    tick();
    drive(0, 0, 8'h00, 64'd0, 5, 5, 0);
    push("be_merge_a5", 0, 64'h11223344AAAAAAAA);
    tick();

    // Zero register.
    drive(1, 0, 8'hFF, 64'hDEAD, 0, 0, 0);
    push("zero_wr_accept", 2, 64'd1);
    push("zero_same_rd0", 0, 64'd0);
    tick();
    drive(0, 0, 8'h00, 64'd0, 0, 0, 0);
    push("zero_rd0", 0, 64'd0);
    push("zero_rd1", 1, 64'd0);
    tick();

    // Randomised traffic, reads often aimed at the write address.
    for (int i = 0; i < 300; i++) begin
      int wa;
      int a0;
      int a1;
      wa = $urandom_range(0, 31);
      a0 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
      a1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
      drive($urandom_range(0, 1) == 1, wa, 8'($urandom), {$urandom, $urandom}, a0, a1, 0);
      tick();
    end

    // Clear sweep with CLR_REQ held through SWEEP (must be ignored there).
    for (int i = 1; i < 32; i++) begin
      drive(1, i, 8'hFF, 64'(i), i, 0, 0);
      tick();
    end
    drive(0, 0, 8'h00, 64'd0, 3, 20, 1);
    tick();
    for (int n = 1; n <= 33; n++) begin
      drive(n == 20, 7, 8'hFF, 64'h77, 3, 20, n <= 32);
      if (n == 20) push("sweep_wr_dropped", 2, 64'd0);
      if (n == 10) begin
        push("sweep_c10_a3", 0, 64'd0);
        push("sweep_c10_a20", 1, 64'd20);
      end
      push("sweep_busy", 3, 64'd1);
      push("sweep_clr_done", 4, (n == 33) ? 64'd1 : 64'd0);
      tick();
    end
    drive(0, 0, 8'h00, 64'd0, 7, 31, 0);
    push("post_sweep_a7", 0, 64'd0);
    push("post_sweep_a31", 1, 64'd0);
    push("post_sweep_busy", 3, 64'd0);
    tick();

    // Write and clear request together, then reset in the middle of the sweep.
    drive(1, 25, 8'hFF, 64'hAB, 0, 0, 0);
    tick();
    drive(1, 4, 8'hFF, 64'h44, 4, 25, 1);
    push("wr_with_clr_accept", 2, 64'd1);
    tick();
    for (int n = 1; n < 12; n++) begin
      drive(0, 0, 8'h00, 64'd0, 4, 25, 0);
      tick();
    end
    RESET_N = 1'b0;
    reset_model();
    drive(0, 0, 8'h00, 64'd0, 25, 4, 0);
    push("midrst_busy", 3, 64'd0);
    push("midrst_a25", 0, 64'd0);
    tick();
    drive(0, 0, 8'h00, 64'd0, 25, 4, 0);
    tick();
    RESET_N = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive(0, 0, 8'h00, 64'd0, i % 16, 31 - (i % 16), 0);
      push("midrst_no_done", 4, 64'd0);
      tick();
    end

    // Same-cycle forwarding (or its absence).
    drive(1, 9, 8'h01, 64'hCAFE, 9, 9, 0);
`ifdef REGFILE_BYPASS_EN
    push("bypass_same_p0", 0, 64'hFE);
    push("bypass_same_p1", 1, 64'hFE);
`else
    push("nobypass_same_p0", 0, 64'h0);
    push("nobypass_same_p1", 1, 64'h0);
`endif
    tick();
    drive(0, 0, 8'h00, 64'd0, 9, 9, 0);
    push("bypass_next_p0", 0, 64'hFE);
    push("bypass_next_p1", 1, 64'hFE);
    tick();

    @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the 64-bit, 32-entry, 2R/1W register file.
- Generalised in width, depth and read-port count. Adds per-byte write enables, an optional hard-wired zero register, and a sequenced bulk-clear engine with busy/done handshake.
- Sits in the datapath between decode (read addresses) and writeback (write port).

Parameters:
- DATA_W, 64, entry width in bits; multiple of 8.
- DEPTH, 32, number of entries; power of two, >= 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- NRD, 2, number of read ports (1..4).
- ZERO_R0, 1, when 1 entry 0 reads as zero and ignores writes.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- WR_EN  in  1  write request.
- WR_ADDR  in  ADDR_W  write address.
- WR_BE  in  DATA_W/8  byte enables; bit i covers bits [8i+7:8i].
- WR_DATA  in  DATA_W  write data.
- WR_ACCEPT  out  1  write committed this cycle (WR_EN & ~BUSY).
- RD_ADDR  in  NRD*ADDR_W  packed read addresses; port p at [p*ADDR_W +: ADDR_W].
- RD_DATA  out  NRD*DATA_W  packed read data, combinational.
- CLR_REQ  in  1  start bulk-clear sweep (single-cycle pulse or level).
- BUSY  out  1  clear sweep in progress.
- CLR_DONE  out  1  one-cycle pulse on the cycle after the last entry is cleared.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - All entries become 0; FSM goes to IDLE; sweep pointer is 0.
  - BUSY=0, CLR_DONE=0, WR_ACCEPT=0.
  - Release is synchronous to CLK.
- Write:
  - On a rising CLK edge with WR_EN=1 and BUSY=0, each byte of entry WR_ADDR with WR_BE[i]=1 takes WR_DATA byte i. Other bytes hold.
  - WR_BE all zero: accepted, no change.
  - ZERO_R0=1 and WR_ADDR=0: WR_ACCEPT=1, storage unchanged.
- Read:
  - Asynchronous: RD_DATA port p = entry[RD_ADDR p].
  - Latency 0 from address; a write becomes visible on the cycle after its edge (see the optional feature for bypass).
  - ZERO_R0=1 and address 0: returns 0.
- Clear FSM:
  - States IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on CLR_REQ=1; pointer is 0.
  - SWEEP: entry[pointer] is cleared each cycle and the pointer increments. Exit when pointer == DEPTH-1 is cleared; go to DONE.
  - DONE: CLR_DONE=1 for one cycle, then IDLE. CLR_REQ is ignored in DONE and SWEEP.
  - CLR_REQ still high in IDLE after DONE starts a new sweep.
  - BUSY=1 in SWEEP and DONE.
  - Sweep of DEPTH entries takes DEPTH cycles; CLR_DONE is asserted on cycle DEPTH+1 after the CLR_REQ edge.
- During BUSY:
  - Writes are dropped (WR_ACCEPT=0); the requester retries.
  - Reads continue. Entries below the pointer read 0; entries at or above it read their old value.
- Simultaneous events:
  - WR_EN and CLR_REQ in the same IDLE cycle: the write commits, then the sweep starts next cycle and will clear it.
  - Reset mid-sweep aborts immediately; all entries are zeroed anyway.
- Pointer width is ADDR_W; there is no wrap beyond DEPTH-1.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - Read port p returns write-forwarded data when WR_ACCEPT=1 and WR_ADDR == RD_ADDR p (and not the zero register).
  - Forwarded value is per byte: WR_DATA where WR_BE is set, stored bytes otherwise. Write-to-read latency is 0 in the same cycle.
- Undefined: no forwarding; reads return stored contents only, and new data appears the cycle after the write edge.

Decomposition:
- Package regfile_pkg:
  - clear-FSM state enum (IDLE/SWEEP/DONE).
  - localparam helper for byte-lane count DATA_W/8.
  - Default width/depth constants (64, 32).
- Sub-module regfile_clr_seq: clear FSM, pointer, BUSY/CLR_DONE. It outputs clr_we and clr_addr to the array.
- Array, byte-merge and read/bypass muxes stay in the top.

Test Plan (DATA_W=64, DEPTH=32, NRD=2, ZERO_R0=1):
- Reset then read all 32 addresses on both ports -> all 0; BUSY=0, CLR_DONE=0.
- Byte-enable merge:
  - Write addr 5 with 64'h1122334455667788, BE=8'hFF.
  - Then write 64'hAAAAAAAAAAAAAAAA, BE=8'h0F.
  - Expect read port 0 addr 5 = 64'h11223344AAAAAAAA.
- Zero register: write addr 0 with 64'hDEAD, BE=8'hFF -> WR_ACCEPT=1; read addr 0 = 0 on both ports.
- Clear sweep:
  - Fill addr 1..31 with the address value.
  - Pulse CLR_REQ.
  - Expect BUSY high for 33 cycles and CLR_DONE on cycle 33.
  - At cycle 10 of the sweep, addr 3 reads 0 and addr 20 reads 20.
  - A write to addr 7 during the sweep gives WR_ACCEPT=0, and the final read of addr 7 is 0.
- Reset mid-sweep: assert RESET_N=0 at sweep cycle 12 -> BUSY=0 immediately, all entries 0, no CLR_DONE pulse.
- Bypass (REGFILE_BYPASS_EN defined):
  - Port 0 and port 1 both read addr 9 (stored 64'h0).
  - In the same cycle write 64'hCAFE, BE=8'h01.
  - Expect RD_DATA = 64'hFE same cycle.
  - Without the macro, 0 that cycle and 64'hFE next cycle.
